// File: rtl/eth_axis_rx_parser_pkg.sv
// Shared constants and types for the Ethernet RX header parser.
package eth_pkg;

    localparam int unsigned ETH_HDR_BYTES = 14;
    localparam int unsigned ETH_MAC_BYTES = 6;
    localparam int unsigned ETH_HDR_BITS  = ETH_HDR_BYTES * 8;
    localparam int unsigned ETH_MAC_BITS  = ETH_MAC_BYTES * 8;

    // Index of the final header byte (EtherType LSB).
    localparam logic [3:0] ETH_HDR_LAST_IDX = 4'(ETH_HDR_BYTES - 1);

    typedef enum logic [1:0] {
        HEADER,
        PAYLOAD,
        DROP
    } eth_rx_state_t;

endpackage

// File: rtl/eth_axis_rx_parser_if.sv
// Parsed Ethernet frame: header with its own handshake plus a byte payload stream.
interface eth_axis_interface;
    import eth_pkg::*;

    logic                    hdr_valid;
    logic                    hdr_ready;
    logic [ETH_MAC_BITS-1:0] dest_mac;
    logic [ETH_MAC_BITS-1:0] src_mac;
    logic [15:0]             eth_type;
    logic [7:0]              tdata;
    logic                    tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;
    logic                    busy;

    modport Source (
        output hdr_valid, dest_mac, src_mac, eth_type,
        input  hdr_ready,
        output tdata, tkeep, tvalid, tlast, tuser, busy,
        input  tready
    );

    modport Sink (
        input  hdr_valid, dest_mac, src_mac, eth_type,
        output hdr_ready,
        input  tdata, tkeep, tvalid, tlast, tuser, busy,
        output tready
    );

endinterface

// File: rtl/eth_axis_rx_parser_byte_reg.sv
// One-entry AXI-stream register slice carrying a byte plus last/user sidebands.
module eth_axis_byte_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_user,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_user,
    output logic       out_valid,
    input  logic       out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Load on input handshake (even while draining), otherwise empty once drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_last  <= in_last;
            out_user  <= in_user;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_axis_rx_parser.sv
// Ethernet RX header parser: strips the 14-byte header off a MAC byte stream,
// presents it with a valid/ready handshake and forwards the payload bytes.
module eth_axis_rx_parser
    import eth_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic                     s_tuser,
    eth_axis_interface.Source        eth_out,
    output logic                     runt_drop
);

    eth_rx_state_t           state, state_d;
    logic [3:0]              cnt, cnt_d;
    logic [ETH_HDR_BITS-1:0] hdr_sr;
    logic                    hdr_valid_r;
    logic                    hdr_set;
    logic                    hdr_shift;
    logic                    runt_d;
    logic                    accept;
    logic                    pay_valid;
    logic                    pay_ready;
    logic [7:0]              pay_data;
    logic                    pay_last;
    logic                    pay_user;
    logic                    pay_out_valid;

    // State and byte counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HEADER;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Input ready, next state, counter and per-byte actions.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        s_tready  = 1'b0;
        hdr_set   = 1'b0;
        hdr_shift = 1'b0;
        runt_d    = 1'b0;
        pay_valid = 1'b0;

        unique case (state)
            HEADER:  s_tready = !hdr_valid_r;
            PAYLOAD: s_tready = pay_ready;
            DROP:    s_tready = 1'b1;
            default: s_tready = 1'b0;
        endcase
        accept = s_tvalid && s_tready;

        unique case (state)
            HEADER: begin
                hdr_shift = accept;
                if (cnt > ETH_HDR_LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = DROP;
                end else if (accept) begin
                    if (s_tlast) begin
                        runt_d = 1'b1;
                        cnt_d  = '0;
                    end else if (cnt == ETH_HDR_LAST_IDX) begin
                        hdr_set = 1'b1;
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end
            PAYLOAD: begin
                pay_valid = s_tvalid;
                if (accept && s_tlast) state_d = HEADER;
            end
            DROP: begin
                if (accept && s_tlast) state_d = HEADER;
            end
            default: state_d = HEADER;
        endcase
    end

    // Header shift register, header valid handshake and runt pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_sr      <= '0;
            hdr_valid_r <= 1'b0;
            runt_drop   <= 1'b0;
        end else begin
            runt_drop <= runt_d;
            if (hdr_shift) hdr_sr <= {hdr_sr[ETH_HDR_BITS-9:0], s_tdata};
            if (hdr_set) hdr_valid_r <= 1'b1;
            else if (hdr_valid_r && eth_out.hdr_ready) hdr_valid_r <= 1'b0;
        end
    end

    eth_axis_byte_reg u_pay_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (s_tdata),
        .in_last   (s_tlast),
        .in_user   (s_tlast && s_tuser),
        .in_valid  (pay_valid),
        .in_ready  (pay_ready),
        .out_data  (pay_data),
        .out_last  (pay_last),
        .out_user  (pay_user),
        .out_valid (pay_out_valid),
        .out_ready (eth_out.tready)
    );

    // Output mapping; busy spans a header in progress through the final payload drain.
    always_comb begin
        eth_out.hdr_valid = hdr_valid_r;
        eth_out.dest_mac  = hdr_sr[ETH_HDR_BITS-1 -: ETH_MAC_BITS];
        eth_out.src_mac   = hdr_sr[ETH_HDR_BITS-ETH_MAC_BITS-1 -: ETH_MAC_BITS];
        eth_out.eth_type  = hdr_sr[15:0];
        eth_out.tdata     = pay_data;
        eth_out.tkeep     = 1'b1;
        eth_out.tvalid    = pay_out_valid;
        eth_out.tlast     = pay_last;
        eth_out.tuser     = pay_user;
        eth_out.busy      = (state != HEADER) || (cnt != '0) || pay_out_valid;
    end

endmodule

// File: tb/tb_eth_axis_rx_parser.sv
// Self-checking bench for eth_axis_rx_parser: table of frames plus hand-written corner sequences.
module tb_eth_axis_rx_parser;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tready, s_tlast, s_tuser, runt_drop;

    eth_axis_interface eo ();

    eth_axis_rx_parser dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .eth_out   (eo),
        .runt_drop (runt_drop)
    );

    always #5 clk = ~clk;

    typedef struct { logic [47:0] d; logic [47:0] s; logic [15:0] t; } hdr_exp_t;
    typedef struct { logic [7:0] data; logic last; logic user; } pay_exp_t;
    typedef struct { int len; bit user; bit rand_bp; bit exp_runt; } frame_vec_t;

    hdr_exp_t hdr_q[$];
    pay_exp_t pay_q[$];
    hdr_exp_t mh;
    pay_exp_t mp;

    int tests = 0, fails = 0;
    int hs_cnt = 0, beats = 0, hv_cycles = 0, tv_cycles = 0, runt_cnt = 0;
    bit sb_en = 1'b1, bp_rand = 1'b0;
    logic       prev_stall;
    logic [9:0] prev_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string n);
        chk({n, "_hdr_valid"}, 64'(eo.hdr_valid), 0);
        chk({n, "_tvalid"},    64'(eo.tvalid), 0);
        chk({n, "_tlast"},     64'(eo.tlast), 0);
        chk({n, "_tuser"},     64'(eo.tuser), 0);
        chk({n, "_busy"},      64'(eo.busy), 0);
        chk({n, "_runt_drop"}, 64'(runt_drop), 0);
        chk({n, "_dest_mac"},  64'(eo.dest_mac), 0);
        chk({n, "_src_mac"},   64'(eo.src_mac), 0);
        chk({n, "_eth_type"},  64'(eo.eth_type), 0);
        chk({n, "_tdata"},     64'(eo.tdata), 0);
        chk({n, "_s_tready"},  64'(s_tready), 1);
    endtask

    // Drives the first nbytes of a frame; header/payload expectations are queued up front.
    task automatic send_frame(input int len, input bit user, input int k, input int nbytes,
                              output int first_wait);
        logic [47:0]  d, s;
        logic [15:0]  et;
        logic [111:0] hv, tmp;
        logic [7:0]   bytes[$];
        pay_exp_t     pe;
        int           w;
        bit           acc, pend;
        d  = 48'h020000000001 + 48'(2 * k);
        s  = d + 48'd1;
        et = 16'h0800 + 16'(k);
        hv = {d, s, et};
        for (int i = 0; i < len; i++) begin
            if (i < 14) begin
                tmp = hv >> (8 * (13 - i));
                bytes.push_back(tmp[7:0]);
            end else begin
                bytes.push_back(8'($urandom));
            end
        end
        if (len > 14) begin
            hdr_q.push_back('{d: d, s: s, t: et});
            for (int i = 14; i < len; i++) begin
                pe.data = bytes[i];
                pe.last = (i == len - 1);
                pe.user = (i == len - 1) ? user : 1'b0;
                pay_q.push_back(pe);
            end
        end
        first_wait = 0;
        pend = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < nbytes; i++) begin
            s_tdata  = bytes[i];
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? user : 1'b0;
            s_tvalid = 1'b1;
            w   = 0;
            acc = 1'b0;
            while (!acc) begin
                @(negedge clk);
                if (pend) begin
                    chk("hdr_valid_latency", 64'(eo.hdr_valid), 1);
                    pend = 1'b0;
                end
                acc = s_tready;
                if (!acc) begin
                    w++;
                    if (w > 500) begin
                        tests++;
                        fails++;
                        $display("FAIL s_tready_timeout: byte %0d never accepted", i);
                        s_tvalid = 1'b0;
                        s_tlast  = 1'b0;
                        return;
                    end
                end else if (i == 13 && len > 14) begin
                    chk("hdr_valid_early", 64'(eo.hdr_valid), 0);
                    pend = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (i == 0) first_wait = w;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((pay_q.size() != 0 || hdr_q.size() != 0 || eo.tvalid || eo.hdr_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_pay_left"}, 64'(pay_q.size()), 0);
        chk({name, "_hdr_left"}, 64'(hdr_q.size()), 0);
    endtask

    // Random output backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_rand) eo.tready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard pops, stall stability and event counters.
    initial begin
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {54'd0, eo.tvalid, eo.tdata, eo.tlast}, {54'd0, prev_out});
                prev_stall = eo.tvalid && !eo.tready;
                prev_out   = {eo.tvalid, eo.tdata, eo.tlast};
                if (eo.hdr_valid) hv_cycles++;
                if (eo.tvalid)    tv_cycles++;
                if (runt_drop)    runt_cnt++;
                if (eo.hdr_valid && eo.hdr_ready) begin
                    hs_cnt++;
                    if (sb_en) begin
                        if (hdr_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL hdr_unexpected: actual=handshake required=none");
                        end else begin
                            mh = hdr_q.pop_front();
                            chk("dest_mac", 64'(eo.dest_mac), 64'(mh.d));
                            chk("src_mac",  64'(eo.src_mac),  64'(mh.s));
                            chk("eth_type", 64'(eo.eth_type), 64'(mh.t));
                        end
                    end
                end
                if (eo.tvalid && eo.tready) begin
                    beats++;
                    if (sb_en) begin
                        if (pay_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL pay_unexpected: actual=%0h required=none", eo.tdata);
                        end else begin
                            mp = pay_q.pop_front();
                            chk("tdata", 64'(eo.tdata), 64'(mp.data));
                            chk("tlast", 64'(eo.tlast), 64'(mp.last));
                            chk("tuser", 64'(eo.tuser), 64'(mp.user));
                            chk("tkeep", 64'(eo.tkeep), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t vec[6];
        int w, w2, r0, h0, t0, b0, s0;

        vec[0] = '{len: 64,  user: 1'b0, rand_bp: 1'b0, exp_runt: 1'b0};
        vec[1] = '{len: 100, user: 1'b0, rand_bp: 1'b1, exp_runt: 1'b0};
        vec[2] = '{len: 10,  user: 1'b0, rand_bp: 1'b0, exp_runt: 1'b1};
        vec[3] = '{len: 14,  user: 1'b1, rand_bp: 1'b0, exp_runt: 1'b1};
        vec[4] = '{len: 15,  user: 1'b1, rand_bp: 1'b0, exp_runt: 1'b0};
        vec[5] = '{len: 1,   user: 1'b0, rand_bp: 1'b0, exp_runt: 1'b1};

        reset_n      = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tlast      = 1'b0;
        s_tuser      = 1'b0;
        eo.hdr_ready = 1'b1;
        eo.tready    = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            r0 = runt_cnt; h0 = hv_cycles; t0 = tv_cycles; b0 = beats; s0 = hs_cnt;
            bp_rand = vec[v].rand_bp;
            send_frame(vec[v].len, vec[v].user, v, vec[v].len, w);
            drain("vec");
            bp_rand   = 1'b0;
            eo.tready = 1'b1;
            chk("runt_pulses", 64'(runt_cnt - r0), vec[v].exp_runt ? 64'd1 : 64'd0);
            if (vec[v].exp_runt) begin
                chk("runt_no_hdr_valid", 64'(hv_cycles - h0), 0);
                chk("runt_no_tvalid",    64'(tv_cycles - t0), 0);
            end else begin
                chk("payload_beats", 64'(beats - b0), 64'(vec[v].len - 14));
                chk("hdr_handshakes", 64'(hs_cnt - s0), 1);
            end
            chk("busy_idle", 64'(eo.busy), 0);
        end

        // Back-to-back frames with the header sink stalled.
        b0 = beats; s0 = hs_cnt;
        eo.hdr_ready = 1'b0;
        fork
            begin
                repeat (30) @(posedge clk);
                #1 eo.hdr_ready = 1'b1;
            end
            begin
                send_frame(20, 1'b0, 10, 20, w);
                send_frame(20, 1'b1, 11, 20, w2);
            end
        join
        drain("b2b");
        chk("b2b_byte0_held", 64'(w2 > 0), 1);
        chk("b2b_beats", 64'(beats - b0), 12);
        chk("b2b_hdrs",  64'(hs_cnt - s0), 2);

        // Reset in the middle of the payload.
        sb_en = 1'b0;
        send_frame(30, 1'b0, 20, 19, w);
        s_tdata  = 8'hAA;
        s_tvalid = 1'b1;
        chk("busy_mid_frame", 64'(eo.busy), 1);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        s_tvalid = 1'b0;
        hdr_q.delete();
        pay_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sb_en   = 1'b1;
        b0 = beats; s0 = hs_cnt;
        send_frame(60, 1'b0, 21, 60, w);
        drain("post_reset");
        chk("post_reset_beats", 64'(beats - b0), 46);
        chk("post_reset_hdrs",  64'(hs_cnt - s0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_axis_rx_parser.md
# eth_axis_rx_parser

Receive-side Ethernet header parser. Consumes the raw byte-wide AXI-stream frame from the MAC and splits it into:
- a header (destination MAC, source MAC, EtherType), presented with a valid/ready handshake;
- a payload byte stream.

Both are presented on an `eth_axis_interface` Source modport. It sits directly between the MAC RX stream and any `eth_axis_interface` Sink (e.g. an IP/ARP demux). Runt frames are discarded.

## Interface
Parameters:
- None. Header length and byte offsets are fixed constants in `eth_pkg`.

Ports:
- `clk`  input  1  sole clock; all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `s_tdata`  input  8  frame byte from MAC; first byte = dest MAC MSB.
- `s_tvalid`  input  1  byte valid.
- `s_tready`  output  1  byte accepted when `s_tvalid && s_tready`.
- `s_tlast`  input  1  last byte of frame.
- `s_tuser`  input  1  frame error flag; meaningful on the `s_tlast` beat.
- `eth_out`  `eth_axis_interface.Source`  —  header fields, `hdr_valid`/`hdr_ready`, payload `tdata`/`tkeep`/`tvalid`/`tready`/`tlast`/`tuser`, and `busy`.
- `runt_drop`  output  1  one-cycle pulse when a frame is discarded as a runt.

## Operation
States: HEADER, PAYLOAD, DROP.

HEADER
- `s_tready = !eth_out.hdr_valid`: a new header is not started until the previous header has been handshaken.
- Each accepted byte shifts into the header register and increments a 4-bit byte counter (0..13).
- Byte order is big-endian:
  - bytes 0–5 → `dest_mac[47:0]`;
  - bytes 6–11 → `src_mac`;
  - bytes 12–13 → `eth_type`.
- Byte 13 accepted with `s_tlast=0`:
  - `hdr_valid` is set on the next edge;
  - the counter clears;
  - state goes to PAYLOAD.
- Any header byte (0–13) accepted with `s_tlast=1`:
  - frame discarded; no `hdr_valid`, no payload;
  - `runt_drop` pulses;
  - counter clears; state stays HEADER.

Header output
- `hdr_valid` is held, with the header fields stable, until `hdr_valid && hdr_ready`. It then clears on the next edge.
- The header handshake is independent of payload flow.

PAYLOAD
- One-entry output register (`tdata`, `tlast`, `tuser`, `tvalid`). `tkeep` is tied to 1.
- `s_tready = !eth_out.tvalid || eth_out.tready`.
- An accepted byte loads the register and sets `tvalid`.
- `tuser` copies `s_tuser` on the `s_tlast` beat and is 0 on other beats.
- When the `s_tlast` byte is accepted, state returns to HEADER. The output register then drains on its own.

DROP
- Reserved for error recovery and entered only on an impossible counter state.
- Accepts and discards bytes until `s_tlast`, then returns to HEADER.

`busy`
- High from the first accepted header byte until the `tlast` payload beat is handshaken on `eth_out`.
- Low during a runt's terminating cycle.

## Timing
- Reset (async assert, sync release): state HEADER, counter 0; all outputs 0, i.e. `hdr_valid`, `tvalid`, `tlast`, `tuser`, `busy`, `runt_drop`, `dest_mac`, `src_mac`, `eth_type`, `tdata`.
- Exception: `s_tready` is 1 after reset, because HEADER with `!hdr_valid` gives `s_tready = 1`.
- `hdr_valid` rises 1 cycle after byte 13 is accepted.
- Payload latency is 1 cycle from input accept to `eth_out.tvalid`.
- Full throughput (1 byte/cycle) with `tready` held high.
- Simultaneous register load and drain in the same cycle is allowed and keeps `tvalid=1`.
- Back-to-back frames: the first header byte of frame N+1 may be accepted in the cycle after frame N's `s_tlast`, provided `hdr_valid` is clear. Otherwise `s_tready` stays low until the header handshake.
- `eth_out` outputs are stable while stalled.
- Reset mid-frame: partial state is discarded, with no `tlast` emitted. Sinks rely on their own reset.
- The counter never wraps beyond 13.

## Structure
- `eth_pkg` holds:
  - `ETH_HDR_BYTES = 14`;
  - `ETH_MAC_BYTES = 6`;
  - the `eth_rx_state_t` enum {HEADER, PAYLOAD, DROP}.
- The payload output stage is a natural sub-module, `eth_axis_byte_reg`: a one-entry AXIS register slice with data, last and user. It is reusable by the TX side.

## Test plan
- 64-byte frame:
  - stimulus: dest `02:00:00:00:00:01`, src `02:00:00:00:00:02`, type `0x0800`, `tready`/`hdr_ready` high;
  - response: `dest_mac=0x020000000001`, `src_mac=0x020000000002`, `eth_type=0x0800`, `hdr_valid` 1 cycle after byte 13; 50 payload bytes in order with `tlast` on the 50th.
- Random `eth_out.tready` backpressure (50%) on a 100-byte frame → all 86 payload bytes delivered in order, none duplicated, `tdata` stable while stalled.
- 10-byte frame with `tlast` on byte 9 → `runt_drop` pulses once; no `hdr_valid` and no `tvalid` ever.
- 14-byte frame (`tlast` on byte 13) → same as the 10-byte case: dropped, `runt_drop` pulses once.
- Two back-to-back 20-byte frames with `hdr_ready` held low for 30 cycles:
  - `s_tready` stays 0 at frame 2 byte 0 until the first header handshake;
  - then both headers and both 6-byte payloads are correct;
  - the second frame's `tuser=1` on its last beat appears on output `tuser`.
- `reset_n` asserted at payload byte 5 of a frame → all outputs 0 immediately. After release, a clean 60-byte frame parses correctly.
